// File: rtl/dmem_pkg.sv
// Shared encodings and default address map for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeBad  = 2'b11
  } size_e;

  typedef enum logic {
    StIdle,
    StResp
  } state_e;

  localparam logic [31:0] DmemBaseDefault = 32'h0200_0000;
  localparam logic [31:0] GpioBaseDefault = 32'h0200_0800;

  localparam logic [31:0] GpioOutOff = 32'h0;
  localparam logic [31:0] GpioOeOff  = 32'h4;
  localparam logic [31:0] GpioInOff  = 32'h8;

endpackage

// File: rtl/dmem_bram.sv
// Single-port RAM with per-byte write enable and registered read data.
module dmem_bram #(
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller for a data RAM and a small GPIO register block.
module data_mem_ctrl import dmem_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned GPIO_WIDTH = 28,
  parameter logic [31:0] DMEM_BASE  = DmemBaseDefault,
  parameter logic [31:0] GPIO_BASE  = GpioBaseDefault
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  input  logic [GPIO_WIDTH-1:0] gpio_in
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] RamLo = (ADDR_WIDTH+1)'(DMEM_BASE);
  localparam logic [ADDR_WIDTH:0] RamHi = RamLo + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  state_e state_q, state_d;
  size_e  sz, size_q;
  logic accept, ok, in_ram, in_gpio, hit_out, hit_oe, hit_in, req_err;
  logic [3:0] lanes;
  logic [31:0] wdata_rep, bram_rdata, shifted, load_fmt, gpio_rd, gpio_rd_q;
  logic [31:0] out_ext, oe_ext, in_ext;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_oe_q, sync1_q, sync2_q;
  logic err_q, we_q, ram_q, uns_q;
  logic [1:0] off_q;

  assign accept = req_valid && req_ready;
  assign sz     = size_e'(req_size);

  // Address decode and fault classification
  always_comb begin
    in_ram  = ({1'b0, req_addr} >= RamLo) && ({1'b0, req_addr} < RamHi);
    hit_out = req_addr == ADDR_WIDTH'(GPIO_BASE + GpioOutOff);
    hit_oe  = req_addr == ADDR_WIDTH'(GPIO_BASE + GpioOeOff);
    hit_in  = req_addr == ADDR_WIDTH'(GPIO_BASE + GpioInOff);
    in_gpio = hit_out || hit_oe || hit_in;
    req_err = (!in_ram && !in_gpio) || (sz == SizeBad) ||
              (sz == SizeHalf && req_addr[0]) ||
              (sz == SizeWord && req_addr[1:0] != 2'b00) ||
              (in_gpio && sz != SizeWord);
    ok = accept && !req_err;
  end

  always_comb begin
    lanes     = 4'b0000;
    wdata_rep = req_wdata;
    unique case (sz)
      SizeByte: begin
        lanes     = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SizeHalf: begin
        lanes     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SizeWord: lanes = 4'b1111;
      default:  lanes = 4'b0000;
    endcase
  end

  dmem_bram #(
    .Depth (MEM_DEPTH),
    .AddrW (IdxW)
  ) u_bram (
    .clk   (clk),
    .en    (ok && in_ram),
    .we    (req_we ? lanes : 4'b0000),
    .addr  (req_addr[IdxW+1:2]),
    .wdata (wdata_rep),
    .rdata (bram_rdata)
  );

  always_comb begin
    out_ext = '0;
    oe_ext  = '0;
    in_ext  = '0;
    out_ext[GPIO_WIDTH-1:0] = gpio_out_q;
    oe_ext[GPIO_WIDTH-1:0]  = gpio_oe_q;
    in_ext[GPIO_WIDTH-1:0]  = sync2_q;
    gpio_rd = hit_out ? out_ext : hit_oe ? oe_ext : hit_in ? in_ext : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (ok && req_we && hit_out) gpio_out_q <= req_wdata[GPIO_WIDTH-1:0];
      if (ok && req_we && hit_oe)  gpio_oe_q  <= req_wdata[GPIO_WIDTH-1:0];
    end
  end

  // Request attributes captured at acceptance keep the response stable while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      ram_q     <= 1'b0;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      size_q    <= SizeWord;
      gpio_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q     <= req_err;
        we_q      <= req_we;
        ram_q     <= in_ram;
        uns_q     <= req_unsigned;
        off_q     <= req_addr[1:0];
        size_q    <= sz;
        gpio_rd_q <= gpio_rd;
      end
    end
  end

  always_comb begin
    shifted  = bram_rdata >> {off_q, 3'b000};
    load_fmt = bram_rdata;
    unique case (size_q)
      SizeByte: load_fmt = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SizeHalf: load_fmt = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:  load_fmt = bram_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? (ram_q ? load_fmt : gpio_rd_q) : '0;
  assign gpio_out  = gpio_out_q;
  assign gpio_oe   = gpio_oe_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 512, number of data RAM words; power of two.
REQ-004 SHALL have parameter GPIO_WIDTH, default 28, number of GPIO bits; range 1..32.
REQ-005 SHALL have parameter DMEM_BASE, default 32'h0200_0000, RAM base byte address.
REQ-006 SHALL have parameter GPIO_BASE, default 32'h0200_0800, GPIO register block base.
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
- rsp_err  out  1  access fault.
- gpio_out  out  GPIO_WIDTH  GPIO output register.
- gpio_oe  out  GPIO_WIDTH  GPIO output-enable register.
- gpio_in  in  GPIO_WIDTH  asynchronous GPIO inputs.

Function
REQ-008 SHALL implement FSM states IDLE and RESP: IDLE->RESP on handshake; RESP->IDLE on rsp handshake; otherwise hold.
REQ-009 SHALL drive req_ready=1 only in IDLE and rsp_valid=1 only in RESP; rsp_valid rises exactly one cycle after acceptance.
REQ-010 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 && rsp_ready=0; one request in flight maximum.
REQ-011 SHALL decode RAM region as DMEM_BASE <= addr < DMEM_BASE+4*MEM_DEPTH, word index addr[log2(MEM_DEPTH)+1:2]; no modulo aliasing.
REQ-012 SHALL decode GPIO region as GPIO_BASE+0 OUT (rw), +4 OE (rw), +8 IN (ro); all other addresses are unmapped.
REQ-013 SHALL flag rsp_err=1 for: unmapped address, req_size=11, half with addr[0]=1, word with addr[1:0]!=0, non-word GPIO access.
REQ-014 SHALL perform no state update (RAM or GPIO) for any request flagged in REQ-013.
REQ-015 SHALL write RAM on the acceptance edge with byte lanes selected by size/addr[1:0], replicating wdata[7:0] (byte) or wdata[15:0] (half) to the selected lanes.
REQ-016 SHALL return load data right-aligned by addr[1:0], sign- or zero-extended per req_unsigned; word loads unaffected.
REQ-017 SHALL make a load following a store to the same address return the stored data.
REQ-018 SHALL ignore writes to the IN register without error; GPIO bits above GPIO_WIDTH read 0.
REQ-019 SHALL pass gpio_in through a 2-flop synchroniser; IN reads return the second flop.

Reset
REQ-020 SHALL, on rst_n=0 at a clock edge, set FSM=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, gpio_oe=0, synchroniser flops=0.
REQ-021 SHALL drop an in-flight response on reset; a store already accepted remains written.
REQ-022 SHALL NOT reset RAM contents; RAM initial contents are undefined.

Structure
REQ-023 SHALL place size encodings, GPIO register offsets and default base addresses in the shared package dmem_pkg.
REQ-024 SHALL use one sub-module, dmem_bram, a MEM_DEPTH x 32 single-port RAM with 4-bit byte write enable and registered read.

Verification
REQ-025 SHALL cover: word store 0xDEADBEEF @0x02000010, then byte load unsigned @0x02000011 -> rsp_rdata=0x000000BE, rsp_err=0.
REQ-026 SHALL cover: half store 0x8001 @0x02000022, then signed half load -> 0xFFFF8001; unsigned -> 0x00008001; word load @0x02000020 -> upper half 0x8001.
REQ-027 SHALL cover: word store @0x02000006 and load @0x02000800+0x10 -> rsp_err=1, RAM/GPIO unchanged; load @0x01FFFFFC -> rsp_err=1.
REQ-028 SHALL cover: store 0x0FFFFFFF to GPIO OUT, 0x0000FFFF to OE -> gpio_out/gpio_oe match next cycle; gpio_in=0x0ABCDEF flipped, IN read after 2 cycles -> 0x0ABCDEF.
REQ-029 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0; rst_n=0 during RESP -> rsp_valid=0 next cycle, gpio_out=0.
